spi_rx_buffer: RTL and testbench
================================

Name: spi_rx_buffer

Overview:
Downstream consumer of the SPI slave's receive-memory write port (rcMemAddr/rcMemData/rcMemWE). Captures one SPI packet's payload bytes into an internal byte RAM and frames the packet on the SPI_SS rising edge. Presents the packet to the host/SysClk logic with a valid/ack handshake and a registered random-access read port. Single-packet buffer: while a packet awaits ack, new SPI traffic is dropped and flagged.

Parameters:
AddrBits, 12, byte-address width; buffer depth = 2**AddrBits bytes.

Ports:
SysClk  in  1  system clock; all logic on rising edge.
Reset  in  1  synchronous, active-high reset.
SPI_SS  in  1  raw SPI slave select, active low; asynchronous to SysClk.
rcMemAddr  in  AddrBits  write byte address from the SPI slave.
rcMemData  in  8  write byte from the SPI slave.
rcMemWE  in  1  one-SysClk write strobe from the SPI slave.
rdAddr  in  AddrBits  host read address.
rdData  out  8  host read data; one cycle latency.
pktValid  out  1  packet captured and awaiting ack.
pktLen  out  AddrBits+1  byte count of the held packet; range 1..2**AddrBits.
pktAck  in  1  host releases the buffer; single-cycle pulse, honoured only while pktValid=1.
overflow  out  1  sticky: the held packet exceeded the buffer depth.
dropped  out  1  sticky: writes arrived while in READY.
debug_out  out  8  {state[1:0], pktValid, overflow, dropped, 3'b000}.

Behaviour:
- SS handling: 2-flop synchronizer (ss_s1, ss_s2) plus ss_prev. fall = ~ss_s2 & ss_prev; rise = ss_s2 & ~ss_prev.
- Reset: state=IDLE, pktValid=0, pktLen=0, overflow=0, dropped=0, byteCount=0, rdData=0. The synchronizer flops reset to 1. RAM contents are not cleared.
- States: IDLE=0, CAPTURE=1, READY=2.
- IDLE:
  - On fall: go to CAPTURE; clear byteCount and overflow.
  - rcMemWE is ignored in IDLE.
- CAPTURE, on rcMemWE:
  - If byteCount < 2**AddrBits: write mem[rcMemAddr] <= rcMemData; byteCount <= rcMemAddr+1, width AddrBits+1, zero-extended.
  - Otherwise, or if rcMemAddr==0 while byteCount!=0 (address wrapped): do not write, set overflow, hold byteCount.
- CAPTURE, on rise:
  - A write in the same cycle as rise is committed first.
  - byteCount (after that write) == 0: return to IDLE. This covers command-only packets and pktValid stays 0.
  - Otherwise: go to READY, pktLen <= byteCount, pktValid <= 1 on the next edge.
  - Latency: pktValid rises exactly 3 SysClk edges after the first edge that samples SPI_SS=1, absent a same-cycle write conflict.
- READY:
  - rcMemWE writes are ignored and set dropped. The RAM is not modified.
  - pktAck: pktValid <= 0 and go to IDLE.
  - pktAck in the same cycle as fall: go directly to CAPTURE (clear byteCount and overflow) so the new packet is not lost.
  - If SS is already low when ack arrives without a coincident fall, the remainder of that packet is not captured; wait for the next fall.
  - pktAck outside READY has no effect.
- dropped is cleared only by Reset or on entry to CAPTURE.
- Read port: rdData <= mem[rdAddr] every cycle, in any state.
  - Read and write to the same address in one cycle returns the old data (read-first).
  - Reading at or beyond pktLen returns stale RAM contents; no error.
- Reset mid-packet: abort to IDLE. Capture restarts only on a fresh fall, after the synchronizer is re-primed high.

Decomposition:
- Shared package spi_pkg: state encodings (IDLE/CAPTURE/READY) and SPI command byte constants (READ_START=1, READ_MORE=2, WRITE_START=3, WRITE_MORE=4, INTERRUPT=5). The SPI slave also uses these.
- One sub-module: spi_byte_ram, a simple dual-port, 1 write/1 read, read-first, registered-output RAM, depth 2**AddrBits. It is reused by the TX-side feeder.

Test Plan:
1. SS low, WE at addrs 0..3 with data 0xA0..0xA3, SS high -> 3 cycles later pktValid=1, pktLen=4; rdAddr=2 -> rdData=0xA2 one cycle later; pktAck -> pktValid=0, state IDLE.
2. SS low/high with no WE (command-only) -> pktValid stays 0, state returns to IDLE, pktLen unchanged.
3. AddrBits=4: write addrs 0..15 then addr 0 again (wrap) -> overflow=1, pktLen=16, mem[0] keeps its first value.
4. While READY, second packet writes addr 0 = 0x55 -> dropped=1, rdAddr=0 still returns the original byte, pktLen unchanged.
5. pktAck in the same cycle as a synchronized SS fall -> state CAPTURE; next packet with 2 bytes yields pktLen=2.
6. Reset asserted after 5 bytes mid-packet -> pktValid=0, overflow=0, state IDLE; a later complete 3-byte packet gives pktLen=3.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave and its receive/transmit side buffers.
//   spiRxState_t : receive buffer state encoding (IDLE/CAPTURE/READY).
//   READ_START .. INTERRUPT : SPI command byte values understood by the slave.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    READY   = 2'd2
  } spiRxState_t;

  localparam logic [7:0] READ_START  = 8'd1;
  localparam logic [7:0] READ_MORE   = 8'd2;
  localparam logic [7:0] WRITE_START = 8'd3;
  localparam logic [7:0] WRITE_MORE  = 8'd4;
  localparam logic [7:0] INTERRUPT   = 8'd5;

endpackage

// File: rtl/spi_byte_ram.sv
// Simple dual-port byte RAM: one write port, one registered read port.
// Read-first: a read and a write to the same address in one cycle return
// the old contents. Contents are never cleared; only the read register resets.
//   SysClk  : clock, rising edge
//   Reset   : synchronous active-high, clears the read data register
//   wrEn    : write strobe
//   wrAddr  : write address
//   wrData  : write data
//   rdAddr  : read address
//   rdData  : read data, one cycle after rdAddr
module spi_byte_ram #(
  parameter int AddrBits = 12,
  parameter int DATA_W   = 8
) (
  input  logic                SysClk,
  input  logic                Reset,
  input  logic                wrEn,
  input  logic [AddrBits-1:0] wrAddr,
  input  logic [DATA_W-1:0]   wrData,
  input  logic [AddrBits-1:0] rdAddr,
  output logic [DATA_W-1:0]   rdData
);

  logic [DATA_W-1:0] mem [2**AddrBits];

  always_ff @(posedge SysClk) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  always_ff @(posedge SysClk) begin
    if (Reset) rdData <= '0;
    else       rdData <= mem[rdAddr];
  end

endmodule

// File: rtl/spi_rx_buffer.sv
// Single-packet receive buffer behind the SPI slave's receive-memory write
// port. Payload bytes are captured while SPI_SS is low; the packet is framed
// on the SS rising edge and held for the host until pktAck. Traffic that
// arrives while a packet is held is discarded and flagged in 'dropped'.
//   SysClk, Reset        : clock and synchronous active-high reset
//   SPI_SS               : raw slave select (active low, asynchronous)
//   rcMemAddr/Data/WE    : byte write port from the SPI slave
//   rdAddr, rdData       : host random-access read, one cycle latency
//   pktValid, pktLen     : held packet flag and its byte count (1..2**AddrBits)
//   pktAck               : host release pulse
//   overflow, dropped    : sticky error flags
//   debug_out            : {state, pktValid, overflow, dropped, 3'b000}
module spi_rx_buffer
  import spi_pkg::*;
#(
  parameter int AddrBits = 12
) (
  input  logic                SysClk,
  input  logic                Reset,
  input  logic                SPI_SS,
  input  logic [AddrBits-1:0] rcMemAddr,
  input  logic [7:0]          rcMemData,
  input  logic                rcMemWE,
  input  logic [AddrBits-1:0] rdAddr,
  output logic [7:0]          rdData,
  output logic                pktValid,
  output logic [AddrBits:0]   pktLen,
  input  logic                pktAck,
  output logic                overflow,
  output logic                dropped,
  output logic [7:0]          debug_out
);

  localparam int CntW = AddrBits + 1;

  spiRxState_t     state, stateNext;
  logic [CntW-1:0] byteCount, byteCountNext, pktLenNext;
  logic            pktValidNext, overflowNext, droppedNext;
  logic            memWe;
  logic            ss_s1, ss_s2, ss_prev;
  logic            ssFall, ssRise;

  assign ssFall = ~ss_s2 & ss_prev;
  assign ssRise = ss_s2 & ~ss_prev;

  // Synchronizer primed high so that a reset never fabricates an edge
  // while SS is idle.
  always_ff @(posedge SysClk) begin
    if (Reset) begin
      ss_s1   <= 1'b1;
      ss_s2   <= 1'b1;
      ss_prev <= 1'b1;
    end else begin
      ss_s1   <= SPI_SS;
      ss_s2   <= ss_s1;
      ss_prev <= ss_s2;
    end
  end

  always_ff @(posedge SysClk) begin
    if (Reset) begin
      state     <= IDLE;
      byteCount <= '0;
      pktLen    <= '0;
      pktValid  <= 1'b0;
      overflow  <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      state     <= stateNext;
      byteCount <= byteCountNext;
      pktLen    <= pktLenNext;
      pktValid  <= pktValidNext;
      overflow  <= overflowNext;
      dropped   <= droppedNext;
    end
  end

  always_comb begin
    stateNext     = state;
    byteCountNext = byteCount;
    pktLenNext    = pktLen;
    pktValidNext  = pktValid;
    overflowNext  = overflow;
    droppedNext   = dropped;
    memWe         = 1'b0;
    case (state)
      IDLE: begin
        if (ssFall) begin
          stateNext     = CAPTURE;
          byteCountNext = '0;
          overflowNext  = 1'b0;
          droppedNext   = 1'b0;
        end
      end
      CAPTURE: begin
        if (rcMemWE) begin
          // Buffer full (MSB of the count set) or the address wrapped back
          // to zero: keep the bytes already captured.
          if (!byteCount[AddrBits] && !(rcMemAddr == '0 && byteCount != '0)) begin
            memWe         = 1'b1;
            byteCountNext = {1'b0, rcMemAddr} + CntW'(1);
          end else begin
            overflowNext = 1'b1;
          end
        end
        // Framing uses the count including a write landing in this cycle.
        if (ssRise) begin
          if (byteCountNext == '0) begin
            stateNext = IDLE;
          end else begin
            stateNext    = READY;
            pktLenNext   = byteCountNext;
            pktValidNext = 1'b1;
          end
        end
      end
      READY: begin
        if (rcMemWE) droppedNext = 1'b1;
        if (pktAck) begin
          pktValidNext = 1'b0;
          // A fall coinciding with the ack starts the next capture at once.
          if (ssFall) begin
            stateNext     = CAPTURE;
            byteCountNext = '0;
            overflowNext  = 1'b0;
            droppedNext   = 1'b0;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  spi_byte_ram #(
    .AddrBits (AddrBits),
    .DATA_W   (8)
  ) uRam (
    .SysClk (SysClk),
    .Reset  (Reset),
    .wrEn   (memWe),
    .wrAddr (rcMemAddr),
    .wrData (rcMemData),
    .rdAddr (rdAddr),
    .rdData (rdData)
  );

  assign debug_out = {state, pktValid, overflow, dropped, 3'b000};

endmodule

// File: tb/tb_spi_rx_buffer.sv
// Scoreboard bench for spi_rx_buffer (AddrBits=4, 16-byte buffer).
// The reference model keeps the buffer as a plain byte array and derives each
// packet's length/overflow from the number of sequential bytes sent.
module tb_spi_rx_buffer;

  localparam int AW    = 4;
  localparam int DEPTH = 2**AW;

  logic          SysClk = 1'b0;
  logic          Reset;
  logic          SPI_SS;
  logic [AW-1:0] rcMemAddr;
  logic [7:0]    rcMemData;
  logic          rcMemWE;
  logic [AW-1:0] rdAddr;
  logic [7:0]    rdData;
  logic          pktValid;
  logic [AW:0]   pktLen;
  logic          pktAck;
  logic          overflow;
  logic          dropped;
  logic [7:0]    debug_out;

  spi_rx_buffer #(.AddrBits(AW)) dut (
    .SysClk    (SysClk),
    .Reset     (Reset),
    .SPI_SS    (SPI_SS),
    .rcMemAddr (rcMemAddr),
    .rcMemData (rcMemData),
    .rcMemWE   (rcMemWE),
    .rdAddr    (rdAddr),
    .rdData    (rdData),
    .pktValid  (pktValid),
    .pktLen    (pktLen),
    .pktAck    (pktAck),
    .overflow  (overflow),
    .dropped   (dropped),
    .debug_out (debug_out)
  );

  always #5 SysClk = ~SysClk;

  typedef struct {
    int len;
    bit ovf;
  } pktExp_t;

  pktExp_t    pktQ[$];
  logic [7:0] rdQ[$];
  logic [7:0] refMem[DEPTH];
  logic [7:0] dataBuf[$];
  int         compared = 0;
  int         mismatched = 0;
  logic       rdIssue = 1'b0;
  logic       rdCheck = 1'b0;
  logic       pvPrev = 1'b0;
  pktExp_t    monExp;
  logic [7:0] monRd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_);
    compared++;
    if (act !== exp_) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp_, $time);
    end
  endtask

  // Monitor: packets are checked when pktValid rises, reads one cycle after issue.
  always @(posedge SysClk) rdCheck <= rdIssue;

  always @(negedge SysClk) begin
    if (Reset !== 1'b1) begin
      if (pktValid === 1'b1 && !pvPrev) begin
        if (pktQ.size() == 0) begin
          check("unexpected_pkt", 32'd1, 32'd0);
        end else begin
          monExp = pktQ.pop_front();
          check("pktLen", 32'(pktLen), 32'(monExp.len));
          check("overflow", 32'(overflow), 32'(monExp.ovf));
        end
      end
      if (rdCheck) begin
        if (rdQ.size() == 0) begin
          check("unexpected_rd", 32'd1, 32'd0);
        end else begin
          monRd = rdQ.pop_front();
          check("rdData", 32'(rdData), 32'(monRd));
        end
      end
    end
    pvPrev <= (pktValid === 1'b1);
  end

  // Lower SS and give the synchronizer and FSM time to enter capture.
  task automatic ssLow();
    @(negedge SysClk) SPI_SS = 1'b0;
    repeat (3) @(negedge SysClk);
  endtask

  task automatic writeBytes(input int n, input bit updModel);
    for (int i = 0; i < n; i++) begin
      @(negedge SysClk);
      rcMemAddr = AW'(i);
      rcMemData = dataBuf[i];
      rcMemWE   = 1'b1;
      if (updModel && i < DEPTH) refMem[i] = dataBuf[i];
      @(negedge SysClk) rcMemWE = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge SysClk);
    end
  endtask

  // Raise SS; for a non-empty packet push the expectation and time pktValid.
  task automatic ssHigh(input int n);
    int lat;
    @(negedge SysClk) SPI_SS = 1'b1;
    if (n > 0) begin
      pktQ.push_back('{len: (n > DEPTH) ? DEPTH : n, ovf: (n > DEPTH)});
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge SysClk);
        if (pktValid === 1'b1) begin
          lat = k;
          break;
        end
      end
      check("pktValid_latency", 32'(lat), 32'd3);
    end else begin
      repeat (5) @(negedge SysClk);
    end
  endtask

  task automatic readByte(input int a);
    @(negedge SysClk);
    rdAddr = AW'(a);
    rdQ.push_back(refMem[a]);
    rdIssue = 1'b1;
    @(negedge SysClk) rdIssue = 1'b0;
  endtask

  task automatic ackPkt();
    @(negedge SysClk) pktAck = 1'b1;
    @(negedge SysClk) pktAck = 1'b0;
    check("ack_pktValid", 32'(pktValid), 32'd0);
    check("ack_state", 32'(debug_out[7:6]), 32'd0);
  endtask

  task automatic randData(input int n);
    dataBuf.delete();
    for (int i = 0; i < n; i++) dataBuf.push_back(8'($urandom));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    Reset = 1'b1; SPI_SS = 1'b1; rcMemAddr = '0; rcMemData = '0; rcMemWE = 1'b0;
    rdAddr = '0; pktAck = 1'b0;
    repeat (3) @(negedge SysClk);
    check("rst_pktValid", 32'(pktValid), 32'd0);
    check("rst_pktLen", 32'(pktLen), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_dropped", 32'(dropped), 32'd0);
    check("rst_rdData", 32'(rdData), 32'd0);
    check("rst_debug", 32'(debug_out), 32'd0);
    Reset = 1'b0;
    repeat (2) @(negedge SysClk);

    // Basic 4-byte packet
    dataBuf = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    ssLow();
    check("capture_state", 32'(debug_out[7:6]), 32'd1);
    writeBytes(4, 1);
    ssHigh(4);
    check("ready_state", 32'(debug_out[7:6]), 32'd2);
    readByte(2);
    ackPkt();

    // Command-only packet: nothing framed, length held
    ssLow();
    ssHigh(0);
    check("cmd_pktValid", 32'(pktValid), 32'd0);
    check("cmd_state", 32'(debug_out[7:6]), 32'd0);
    check("cmd_pktLen", 32'(pktLen), 32'd4);

    // Address wrap after a full buffer
    randData(DEPTH + 1);
    ssLow();
    writeBytes(DEPTH + 1, 1);
    ssHigh(DEPTH + 1);
    readByte(0);
    readByte(DEPTH - 1);

    // Traffic while READY is dropped and leaves the RAM alone
    dataBuf = '{8'h55};
    ssLow();
    writeBytes(1, 0);
    ssHigh(0);
    check("drop_dropped", 32'(dropped), 32'd1);
    check("drop_pktValid", 32'(pktValid), 32'd1);
    check("drop_pktLen", 32'(pktLen), 32'(DEPTH));
    readByte(0);
    ackPkt();
    check("dropped_sticky", 32'(dropped), 32'd1);

    // Ack coinciding with the synchronized SS fall
    randData(3);
    ssLow();
    writeBytes(3, 1);
    ssHigh(3);
    @(negedge SysClk) SPI_SS = 1'b0;
    @(negedge SysClk);
    @(negedge SysClk) pktAck = 1'b1;
    @(negedge SysClk) pktAck = 1'b0;
    check("ackfall_state", 32'(debug_out[7:6]), 32'd1);
    check("ackfall_pktValid", 32'(pktValid), 32'd0);
    check("ackfall_dropped", 32'(dropped), 32'd0);
    randData(2);
    writeBytes(2, 1);
    ssHigh(2);
    readByte(1);
    ackPkt();

    // Reset in the middle of a packet
    randData(5);
    ssLow();
    writeBytes(5, 1);
    @(negedge SysClk) begin Reset = 1'b1; SPI_SS = 1'b1; end
    repeat (3) @(negedge SysClk);
    check("midrst_pktValid", 32'(pktValid), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    check("midrst_state", 32'(debug_out[7:6]), 32'd0);
    Reset = 1'b0;
    repeat (4) @(negedge SysClk);
    check("postrst_state", 32'(debug_out[7:6]), 32'd0);
    randData(3);
    ssLow();
    writeBytes(3, 1);
    ssHigh(3);
    readByte(2);
    ackPkt();

    // Randomized packets
    for (int p = 0; p < 8; p++) begin
      n = $urandom_range(1, DEPTH);
      randData(n);
      ssLow();
      writeBytes(n, 1);
      ssHigh(n);
      for (int r = 0; r < 3; r++) readByte($urandom_range(0, n - 1));
      ackPkt();
    end

    repeat (4) @(negedge SysClk);
    check("pktQ_drained", 32'(pktQ.size()), 32'd0);
    check("rdQ_drained", 32'(rdQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
